// File: rtl/tribus_arbiter_pkg.sv
`default_nettype none
// tribus_arbiter_pkg: state encodings and default sizing for the tristate-bus arbiter.
// Rev 1.0
package tribus_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_TA    = 2'd2
  } state_t;

  localparam int DEF_N         = 4;
  localparam int DEF_MAX_HOLD  = 8;
  localparam int DEF_TA_CYCLES = 1;

endpackage
`default_nettype wire

// File: rtl/tribus_arbiter_rr_pick.sv
`default_nettype none
// tribus_arbiter_rr_pick: combinational round-robin winner search starting after last_owner.
// Rev 1.0
module tribus_arbiter_rr_pick #(
  parameter int N = 4
) (
  input  logic [N-1:0] req,
  input  logic [2:0]   last_owner,
  output logic         found,
  output logic [2:0]   win_id
);

  localparam int IW = $clog2(2 * N);

  logic [2*N-1:0] dbl;
  logic [3:0]     base;
  logic [3:0]     sum;
  logic [IW-1:0]  idx;

  // Two copies back to back let the wrap-around search be a plain upward scan.
  assign dbl = {req, req};

  always_comb begin
    base = {1'b0, last_owner} + 4'd1;
    if (base >= 4'(N)) begin
      base = 4'd0;
    end
    found = 1'b0;
    sum   = base;
    idx   = '0;
    // Scan from the far end so the lowest offset (highest priority) wins last.
    for (int k = N - 1; k >= 0; k--) begin
      idx = IW'(base) + IW'(k);
      if (dbl[idx]) begin
        found = 1'b1;
        sum   = base + 4'(k);
      end
    end
    if (sum >= 4'(N)) begin
      sum = sum - 4'(N);
    end
    win_id = sum[2:0];
  end

endmodule
`default_nettype wire

// File: rtl/tribus_arbiter.sv
`default_nettype none
// tribus_arbiter: round-robin owner of a shared tristate bus with hold cap and turnaround gap.
// Rev 1.0
module tribus_arbiter
  import tribus_arbiter_pkg::*;
#(
  parameter int N         = DEF_N,
  parameter int MAX_HOLD  = DEF_MAX_HOLD,
  parameter int TA_CYCLES = DEF_TA_CYCLES
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [N-1:0] req,
  output logic [N-1:0] en,
  output logic [2:0]   grant_id,
  output logic         bus_busy,
  output logic         ta
);

  state_t       state_q, state_d;
  logic [N-1:0] en_q, en_d;
  logic [2:0]   grant_id_q, grant_id_d;
  logic         bus_busy_q, bus_busy_d;
  logic         ta_q, ta_d;
  logic [2:0]   last_owner_q, last_owner_d;
  logic [3:0]   hold_q, hold_d;
  logic [1:0]   ta_cnt_q, ta_cnt_d;

  logic         found;
  logic [2:0]   win_id;
  logic [N-1:0] win_en;
  logic         owner_req;

  tribus_arbiter_rr_pick #(
    .N (N)
  ) u_rr_pick (
    .req        (req),
    .last_owner (last_owner_q),
    .found      (found),
    .win_id     (win_id)
  );

  assign win_en    = {{(N-1){1'b0}}, 1'b1} << win_id;
  // en_q is one-hot on the owner while granted, so this isolates the owner's request.
  assign owner_req = |(req & en_q);

  always_comb begin
    state_d      = state_q;
    en_d         = en_q;
    grant_id_d   = grant_id_q;
    bus_busy_d   = bus_busy_q;
    ta_d         = ta_q;
    last_owner_d = last_owner_q;
    hold_d       = hold_q;
    ta_cnt_d     = ta_cnt_q;

    case (state_q)
      ST_IDLE: begin
        if (found) begin
          state_d    = ST_GRANT;
          en_d       = win_en;
          grant_id_d = win_id;
          bus_busy_d = 1'b1;
          hold_d     = 4'd1;
        end
      end

      ST_GRANT: begin
        if (owner_req && (hold_q < 4'(MAX_HOLD))) begin
          hold_d = hold_q + 4'd1;
        end else begin
          state_d      = ST_TA;
          en_d         = '0;
          bus_busy_d   = 1'b0;
          ta_d         = 1'b1;
          last_owner_d = grant_id_q;
          ta_cnt_d     = 2'd1;
        end
      end

      ST_TA: begin
        // Arbitration happens only on the final dead cycle; no direct handoff exists.
        if (ta_cnt_q == 2'(TA_CYCLES)) begin
          ta_d = 1'b0;
          if (found) begin
            state_d    = ST_GRANT;
            en_d       = win_en;
            grant_id_d = win_id;
            bus_busy_d = 1'b1;
            hold_d     = 4'd1;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          ta_cnt_d = ta_cnt_q + 2'd1;
        end
      end

      default: begin
        state_d    = ST_IDLE;
        en_d       = '0;
        bus_busy_d = 1'b0;
        ta_d       = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      en_q         <= '0;
      grant_id_q   <= 3'd0;
      bus_busy_q   <= 1'b0;
      ta_q         <= 1'b0;
      last_owner_q <= 3'(N - 1);
      hold_q       <= 4'd0;
      ta_cnt_q     <= 2'd0;
    end else begin
      state_q      <= state_d;
      en_q         <= en_d;
      grant_id_q   <= grant_id_d;
      bus_busy_q   <= bus_busy_d;
      ta_q         <= ta_d;
      last_owner_q <= last_owner_d;
      hold_q       <= hold_d;
      ta_cnt_q     <= ta_cnt_d;
    end
  end

  assign en       = en_q;
  assign grant_id = grant_id_q;
  assign bus_busy = bus_busy_q;
  assign ta       = ta_q;

endmodule
`default_nettype wire

// File: tb/tb_tribus_arbiter.sv
`default_nettype none
// tb_tribus_arbiter: two arbiter instances (TA_CYCLES=1 and 2) checked cycle by cycle against a bus-ownership model.
module tb_tribus_arbiter;

  localparam int N  = 4;
  localparam int MH = 8;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [3:0] req_a = '0, req_b = '0;
  logic [3:0] en_a, en_b;
  logic [2:0] gid_a, gid_b;
  logic       busy_a, busy_b, ta_a, ta_b;

  int n_checks = 0;
  int n_fail   = 0;
  int run_a    = 0;

  // Model: who owns the bus, how long, how many dead cycles remain, who owned last.
  int m_owner[2];
  int m_held[2];
  int m_gap[2];
  int m_last[2];
  int m_ta[2] = '{1, 2};

  always #5 clk = ~clk;

  tribus_arbiter #(.N(N), .MAX_HOLD(MH), .TA_CYCLES(1)) u_dut_a (
    .clk(clk), .reset_n(reset_n), .req(req_a),
    .en(en_a), .grant_id(gid_a), .bus_busy(busy_a), .ta(ta_a)
  );

  tribus_arbiter #(.N(N), .MAX_HOLD(MH), .TA_CYCLES(2)) u_dut_b (
    .clk(clk), .reset_n(reset_n), .req(req_b),
    .en(en_b), .grant_id(gid_b), .bus_busy(busy_b), .ta(ta_b)
  );

  function automatic int pick(logic [3:0] r, int last);
    for (int i = 1; i <= N; i++) begin
      int c;
      c = (last + i) % N;
      if (r[c]) return c;
    end
    return -1;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_owner[k] = -1;
      m_held[k]  = 0;
      m_gap[k]   = 0;
      m_last[k]  = N - 1;
    end
  endtask

  task automatic model_step(input int k, input logic [3:0] r);
    if (m_owner[k] >= 0) begin
      if (r[m_owner[k]] && m_held[k] < MH) begin
        m_held[k]++;
      end else begin
        m_last[k]  = m_owner[k];
        m_owner[k] = -1;
        m_gap[k]   = m_ta[k];
      end
    end else if (m_gap[k] > 1) begin
      m_gap[k]--;
    end else begin
      m_gap[k]   = 0;
      m_owner[k] = pick(r, m_last[k]);
      m_held[k]  = 1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s @%0t: observed %0h expected %0h", tag, $time, obs, exp);
    end
  endtask

  task automatic check_dut(input int k, input logic [3:0] en, input logic [2:0] gid,
                           input logic busy, input logic tav);
    logic [3:0] exp_en;
    exp_en = (m_owner[k] >= 0) ? 4'(1 << m_owner[k]) : 4'd0;
    check($sformatf("en%0d", k), 32'(en), 32'(exp_en));
    check($sformatf("busy%0d", k), 32'(busy), 32'(m_owner[k] >= 0));
    check($sformatf("ta%0d", k), 32'(tav), 32'(m_gap[k] > 0));
    check($sformatf("onehot0_%0d", k), 32'($onehot0(en)), 32'd1);
    if (m_owner[k] >= 0) check($sformatf("gid%0d", k), 32'(gid), 32'(m_owner[k]));
  endtask

  task automatic cycle(input logic [3:0] ra, input logic [3:0] rb);
    req_a = ra;
    req_b = rb;
    @(posedge clk);
    model_step(0, ra);
    model_step(1, rb);
    #1;
    check_dut(0, en_a, gid_a, busy_a, ta_a);
    check_dut(1, en_b, gid_b, busy_b, ta_b);
    run_a = (en_a != 4'd0) ? run_a + 1 : 0;
    check("hold_cap", 32'(run_a <= MH), 32'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_en_a"}, 32'(en_a), 32'd0);
    check({tag, "_busy_a"}, 32'(busy_a), 32'd0);
    check({tag, "_ta_a"}, 32'(ta_a), 32'd0);
    check({tag, "_gid_a"}, 32'(gid_a), 32'd0);
    check({tag, "_en_b"}, 32'(en_b), 32'd0);
    check({tag, "_busy_b"}, 32'(busy_b), 32'd0);
  endtask

  initial begin
    logic [3:0] ra, rb;
    model_reset();

    // Reset held with all requests high: nothing may be granted.
    req_a = 4'b1111;
    req_b = 4'b1111;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check_reset_outputs("reset");
    end
    req_a = 4'b0000;
    req_b = 4'b0000;
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) cycle(4'b0000, 4'b0000);

    // Round robin from reset: 0,1,2,3,0 with 8-cycle tenures; B sees 0011 with 2-cycle gaps.
    for (int i = 0; i < 4 * (MH + 1) + 4; i++) cycle(4'b1111, 4'b0011);
    for (int i = 0; i < 4; i++) cycle(4'b0000, 4'b0011);

    // Single request for three cycles.
    for (int i = 0; i < 3; i++) cycle(4'b0100, 4'b0011);
    for (int i = 0; i < 3; i++) cycle(4'b0000, 4'b0011);

    // Hold cap with one requester permanently high.
    for (int i = 0; i < 20; i++) cycle(4'b0001, 4'b0011);
    for (int i = 0; i < 3; i++) cycle(4'b0000, 4'b0000);

    // Owner 1 drops as requester 3 rises on the same edge.
    for (int i = 0; i < 3; i++) cycle(4'b0010, 4'b0010);
    for (int i = 0; i < 4; i++) cycle(4'b1000, 4'b1000);
    for (int i = 0; i < 3; i++) cycle(4'b0000, 4'b0000);

    // Random sticky request patterns.
    ra = '0;
    rb = '0;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) == 0) ra = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) rb = 4'($urandom_range(0, 15));
      cycle(ra, rb);
    end

    // Asynchronous reset in the middle of a grant.
    for (int i = 0; i < 3; i++) cycle(4'b1111, 4'b1111);
    #2;
    reset_n = 1'b0;
    #1;
    check_reset_outputs("async_reset");
    model_reset();
    @(posedge clk);
    #1;
    check_reset_outputs("reset_hold");
    reset_n = 1'b1;
    run_a = 0;
    for (int i = 0; i < 12; i++) cycle(4'b1111, 4'b1111);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
